iob_asym_fifo_ctrl: RTL

//  Single-clock FIFO controller for the two-port asymmetric RAM with the wide read port (R_DATA_W > W_DATA_W).

---
 rtl/iob_asym_fifo_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/iob_asym_fifo_ctrl.sv
// Single-clock FIFO controller for an asymmetric RAM: narrow words in, wide words out.
// Tracks pointers, fill level and sticky error flags; read data returns one cycle after a pop.
module iob_asym_fifo_ctrl #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int W_ADDR_W = 6,
    parameter int R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [W_ADDR_W:0]   level,
    output logic                overflow,
    output logic                underflow,
    input  logic                clear,
    output logic                ext_mem_w_en,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
);

    localparam int RATIO = R_DATA_W / W_DATA_W;
    localparam int DEPTH = 2 ** W_ADDR_W;
    localparam logic [W_ADDR_W:0] RATIO_L = (W_ADDR_W + 1)'(RATIO);
    localparam logic [W_ADDR_W:0] DEPTH_L = (W_ADDR_W + 1)'(DEPTH);

    logic [W_ADDR_W:0] r_wptr;
    logic [R_ADDR_W:0] r_rptr;
    logic [W_ADDR_W:0] r_level;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push;
    logic              w_pop;
    logic [W_ADDR_W:0] w_level_next;
    logic              w_unused_msbs;

    // Flags come only from the registered level, so a same-cycle pop never frees room for a push.
    assign w_full  = (r_level == DEPTH_L);
    assign r_empty = (r_level < RATIO_L);
    assign w_push  = w_en & ~w_full;
    assign w_pop   = r_en & ~r_empty;

    assign w_level_next = r_level + (W_ADDR_W + 1)'(w_push) - (w_pop ? RATIO_L : '0);

    assign ext_mem_w_en   = w_push;
    assign ext_mem_w_addr = r_wptr[W_ADDR_W-1:0];
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = w_pop;
    assign ext_mem_r_addr = r_rptr[R_ADDR_W-1:0];

    assign r_data    = ext_mem_r_data;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Pointer wrap bits are kept for debug visibility; fullness is decided by the level counter.
    assign w_unused_msbs = r_wptr[W_ADDR_W] ^ r_rptr[R_ADDR_W];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= r_wptr + (W_ADDR_W + 1)'(w_push);
            r_rptr      <= r_rptr + (R_ADDR_W + 1)'(w_pop);
            r_level     <= w_level_next;
            r_valid     <= w_pop;
            r_overflow  <= r_overflow | (w_en & w_full);
            r_underflow <= r_underflow | (r_en & r_empty);
        end
    end

endmodule
